sync_fifo: RTL and testbench



---
 rtl/sync_fifo_pkg.sv | 24 ++
 rtl/sync_fifo_mem.sv | 28 ++
 rtl/sync_fifo.sv | 87 ++++++++
 tb/tb_sync_fifo.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_pkg.sv
// Shared types for the single-clock FWFT staging FIFO: the registered flag
// bundle, its reset value and the occupancy-to-flags decode.
package sync_fifo_pkg;

    typedef struct packed {
        logic full;
        logic afull;
        logic empty;
        logic aempty;
    } fifo_flags_t;

    localparam fifo_flags_t FLAGS_RST = '{full: 1'b0, afull: 1'b0, empty: 1'b1, aempty: 1'b1};

    // Occupancy is passed zero-extended so one decode serves every ASIZE.
    function automatic fifo_flags_t flags_f(input logic [31:0] cnt, input logic [31:0] depth);
        fifo_flags_t f;
        f.full   = (cnt == depth);
        f.afull  = (cnt >= (depth - 32'd1));
        f.empty  = (cnt == 32'd0);
        f.aempty = (cnt <= 32'd1);
        return f;
    endfunction

endpackage

// File: rtl/sync_fifo_mem.sv
// DEPTH x DSIZE register array: synchronous write port, asynchronous read port.
// Contents are deliberately not reset; the pointers define what is valid.
module sync_fifo_mem #(
    parameter int DSIZE = 32,
    parameter int ASIZE = 2
) (
    input  logic             clk,
    input  logic             i_wen,
    input  logic [ASIZE-1:0] i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [ASIZE-1:0] i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    localparam int DEPTH = 32'd1 << ASIZE;

    logic [DSIZE-1:0] r_mem [0:DEPTH-1];

    // Write port: store one word per accepted push.
    always_ff @(posedge clk) begin
        if (i_wen) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with full/empty and almost flags.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module sync_fifo
    import sync_fifo_pkg::*;
#(
    parameter int DSIZE = 32,
    parameter int ASIZE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             winc,
    input  logic [DSIZE-1:0] wdata,
    output logic             wfull,
    output logic             awfull,
    input  logic             rinc,
    output logic [DSIZE-1:0] rdata,
    output logic             rempty,
    output logic             arempty
);

    localparam int             DEPTH   = 32'd1 << ASIZE;
    localparam logic [ASIZE:0] PTR_ONE = {{ASIZE{1'b0}}, 1'b1};

    logic [ASIZE:0] r_wptr;
    logic [ASIZE:0] r_rptr;
    fifo_flags_t    r_flags;

    logic           w_wr_en;
    logic           w_rd_en;
    logic [ASIZE:0] w_wptr_nxt;
    logic [ASIZE:0] w_rptr_nxt;
    logic [ASIZE:0] w_cnt_nxt;
    fifo_flags_t    w_flags_nxt;

    // Reset wins over both requests, so a write during reset never touches memory.
    assign w_wr_en = winc & ~r_flags.full & ~rst;
    assign w_rd_en = rinc & ~r_flags.empty & ~rst;

    // Next pointers, next occupancy and the flags it implies.
    always_comb begin
        w_wptr_nxt = r_wptr;
        w_rptr_nxt = r_rptr;
        if (w_wr_en) begin
            w_wptr_nxt = r_wptr + PTR_ONE;
        end else begin
            w_wptr_nxt = r_wptr;
        end
        if (w_rd_en) begin
            w_rptr_nxt = r_rptr + PTR_ONE;
        end else begin
            w_rptr_nxt = r_rptr;
        end
        w_cnt_nxt   = w_wptr_nxt - w_rptr_nxt;
        w_flags_nxt = flags_f(32'(w_cnt_nxt), 32'(DEPTH));
    end

    // Pointer and flag registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_flags <= FLAGS_RST;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_flags <= w_flags_nxt;
        end
    end

    sync_fifo_mem #(
        .DSIZE (DSIZE),
        .ASIZE (ASIZE)
    ) u_mem (
        .clk     (clk),
        .i_wen   (w_wr_en),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (rdata)
    );

    assign wfull   = r_flags.full;
    assign awfull  = r_flags.afull;
    assign rempty  = r_flags.empty;
    assign arempty = r_flags.aempty;

endmodule

// File: tb/tb_sync_fifo.sv
// Scoreboard bench for sync_fifo (DSIZE=33, ASIZE=2): a queue models the
// contents; flags and the head word are compared against it every cycle.
module tb_sync_fifo;

    localparam int DSIZE = 33;
    localparam int ASIZE = 2;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             winc = 1'b0;
    logic [DSIZE-1:0] wdata = '0;
    logic             rinc = 1'b0;
    logic             wfull;
    logic             awfull;
    logic [DSIZE-1:0] rdata;
    logic             rempty;
    logic             arempty;

    logic [DSIZE-1:0] exp_q[$];
    int               n_checks = 0;
    int               n_pass   = 0;

    sync_fifo #(.DSIZE(DSIZE), .ASIZE(ASIZE)) dut (
        .clk     (clk),
        .rst     (rst),
        .winc    (winc),
        .wdata   (wdata),
        .wfull   (wfull),
        .awfull  (awfull),
        .rinc    (rinc),
        .rdata   (rdata),
        .rempty  (rempty),
        .arempty (arempty)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_flags();
        int cnt;
        cnt = exp_q.size();
        check_val("rempty",  rempty,  (cnt == 0));
        check_val("arempty", arempty, (cnt <= 1));
        check_val("wfull",   wfull,   (cnt == DEPTH));
        check_val("awfull",  awfull,  (cnt >= DEPTH - 1));
        if (cnt > 0) check_val("head", rdata, exp_q[0]);
    endtask

    // One clock: drive, check the popped word before the edge, update the model after it.
    task automatic cycle(input logic rs, input logic w, input logic [DSIZE-1:0] d, input logic r);
        bit wr_ok;
        bit rd_ok;
        rst = rs; winc = w; wdata = d; rinc = r;
        wr_ok = !rs && w && (exp_q.size() < DEPTH);
        rd_ok = !rs && r && (exp_q.size() > 0);
        if (rd_ok) check_val("rd_data", rdata, exp_q[0]);
        @(posedge clk);
        #1;
        if (rs) begin
            exp_q.delete();
        end else begin
            if (rd_ok) void'(exp_q.pop_front());
            if (wr_ok) exp_q.push_back(d);
        end
        rst = 1'b0; winc = 1'b0; rinc = 1'b0;
        check_flags();
    endtask

    initial begin
        int sent;
        int popped;
        int guard;
        logic [31:0] rnd;
        bit w;
        bit r;
        logic [DSIZE-1:0] d;

        // Reset with both requests asserted: nothing may be stored.
        cycle(1'b1, 1'b1, 33'h0_DEAD_BEEF, 1'b1);
        cycle(1'b1, 1'b1, 33'h1_1234_5678, 1'b1);
        check_val("rst_rempty", rempty, 1'b1);
        check_val("rst_wfull", wfull, 1'b0);
        cycle(1'b0, 1'b0, '0, 1'b0);
        check_val("post_rst_empty", rempty, 1'b1);

        // Single word, then pop it.
        cycle(1'b0, 1'b1, 33'h1_0000_1000, 1'b0);
        check_val("one_rdata", rdata, 33'h1_0000_1000);
        check_val("one_arempty", arempty, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("one_popped", rempty, 1'b1);

        // Fill to full, drop a fifth write, drain in order.
        cycle(1'b0, 1'b1, 33'hA, 1'b0);
        cycle(1'b0, 1'b1, 33'hB, 1'b0);
        check_val("two_awfull", awfull, 1'b0);
        cycle(1'b0, 1'b1, 33'hC, 1'b0);
        check_val("three_awfull", awfull, 1'b1);
        check_val("three_wfull", wfull, 1'b0);
        cycle(1'b0, 1'b1, 33'hD, 1'b0);
        check_val("four_wfull", wfull, 1'b1);
        cycle(1'b0, 1'b1, 33'hE, 1'b0);
        check_val("drop_head", rdata, 33'hA);
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("drained", rempty, 1'b1);

        // Simultaneous push/pop on full, then on empty.
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 33'(32'h10 + i), 1'b0);
        cycle(1'b0, 1'b1, 33'h1_5555_5555, 1'b1);
        check_val("full_both_wfull", wfull, 1'b0);
        check_val("full_both_head", rdata, 33'h11);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("full_both_drained", rempty, 1'b1);
        cycle(1'b0, 1'b1, 33'h0_7777_0001, 1'b1);
        check_val("empty_both_rdata", rdata, 33'h0_7777_0001);
        check_val("empty_both_arempty", arempty, 1'b1);
        cycle(1'b0, 1'b0, '0, 1'b1);

        // Random streaming of 20 words across several pointer wraps.
        sent = 0; popped = 0; guard = 0;
        while ((sent < 20 || exp_q.size() > 0) && guard < 2000) begin
            rnd = $urandom;
            d = {rnd[0], 32'($urandom)};
            w = (sent < 20) && ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 1) == 1);
            if (w && exp_q.size() < DEPTH) sent++;
            if (r && exp_q.size() > 0) popped++;
            cycle(1'b0, w, d, r);
            guard++;
        end
        check_val("stream_done", (guard < 2000), 1'b1);
        check_val("stream_pops", popped, 20);

        // Reset mid-operation discards contents.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 33'(32'h20 + i), 1'b0);
        cycle(1'b1, 1'b0, '0, 1'b0);
        check_val("mid_rst_empty", rempty, 1'b1);
        check_val("mid_rst_wfull", wfull, 1'b0);
        cycle(1'b0, 1'b1, 33'h1_CAFE_0042, 1'b0);
        check_val("after_rst_rdata", rdata, 33'h1_CAFE_0042);
        cycle(1'b0, 1'b0, '0, 1'b1);
        check_val("after_rst_empty", rempty, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
